// File: rtl/common_types_pkg.sv
// Shared datapath types plus the memory request unit's access sizes, FSM states and store-size codes.
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } ru_state_t;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_BYTE = 2'd1;
  localparam logic [1:0] ST_HALF = 2'd2;
  localparam logic [1:0] ST_WORD = 2'd3;

  function automatic mem_size_t store_size(input logic [1:0] dwrite);
    case (dwrite)
      ST_BYTE: return BYTE;
      ST_HALF: return HALF;
      default: return WORD;
    endcase
  endfunction

  // Load size code 3 is unused by the control unit; treat it as a word.
  function automatic mem_size_t load_size(input logic [1:0] code);
    case (code)
      2'd0:    return BYTE;
      2'd1:    return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic [1:0] align_offset(input mem_size_t size, input logic [1:0] a);
    case (size)
      BYTE:    return a;
      HALF:    return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] a);
    case (size)
      HALF:    return a[0];
      WORD:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane extraction: shift the bus word down to the addressed lane, mask to size, extend.
module load_extend
  import common_types_pkg::*;
(
  input  word_t     rdata_i,
  input  logic [1:0] offset_i,
  input  mem_size_t size_i,
  input  logic      signed_i,
  output word_t     data_o
);

  word_t shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      BYTE:    data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      HALF:    data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_request_unit.sv
// Shares one memory bus between fetch and data access (data first, one transaction outstanding).
// Hit 2 cycles after request plus bus wait cycles; MISALIGN_TRAP_EN turns misaligned data accesses into error hits.
module mem_request_unit
  import common_types_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iren,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dread,
  input  logic [1:0]        dwrite,
  input  logic [1:0]        reg_wr_mem,
  input  logic              reg_wr_mem_signed,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dstore,
  input  logic              halt,
  output logic              ihit,
  output logic [31:0]       iload,
  output logic              dhit,
  output logic [31:0]       dload,
  output logic              misalign_err,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_strb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  ru_state_t         state_q;
  logic              is_data_q;
  mem_size_t         size_q;
  logic [1:0]        off_q;
  logic              sgn_q;
  logic              ihit_q, dhit_q, mem_req_q, mem_wen_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q, iload_q, dload_q;
  logic [3:0]        mem_strb_q;

  logic              data_req, req_wen;
  mem_size_t         req_size;
  logic [1:0]        req_off;
  logic [3:0]        req_strb;
  logic [31:0]       req_wdata;
  word_t             ext_data;

  always_comb begin
    data_req  = dread | (dwrite != ST_NONE);
    req_wen   = dwrite != ST_NONE;
    req_size  = req_wen ? store_size(dwrite) : load_size(reg_wr_mem);
    req_off   = align_offset(req_size, daddr[1:0]);
    req_strb  = 4'b0000;
    req_wdata = dstore;
    case (req_size)
      BYTE: begin
        req_strb  = 4'b0001 << req_off;
        req_wdata = {4{dstore[7:0]}};
      end
      HALF: begin
        req_strb  = 4'b0011 << req_off;
        req_wdata = {2{dstore[15:0]}};
      end
      default: req_strb = 4'b1111;
    endcase
    if (!req_wen) req_strb = 4'b0000;
  end

  load_extend u_load_extend (
    .rdata_i  (mem_rdata),
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .data_o   (ext_data)
  );

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  logic req_mis;
  assign req_mis      = is_misaligned(req_size, daddr[1:0]);
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      is_data_q   <= 1'b0;
      size_q      <= BYTE;
      off_q       <= 2'b00;
      sgn_q       <= 1'b0;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_strb_q  <= '0;
      iload_q     <= '0;
      dload_q     <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (data_req) begin
            is_data_q   <= 1'b1;
            size_q      <= req_size;
            off_q       <= req_off;
            sgn_q       <= reg_wr_mem_signed;
            mem_wen_q   <= req_wen;
            mem_addr_q  <= daddr & WORD_MASK;
            mem_wdata_q <= req_wdata;
            mem_strb_q  <= req_strb;
`ifdef MISALIGN_TRAP_EN
            if (req_mis) begin
              state_q    <= RESP;
              dhit_q     <= 1'b1;
              misalign_q <= 1'b1;
              dload_q    <= '0;
            end else begin
              state_q   <= BUSY;
              mem_req_q <= 1'b1;
            end
`else
            state_q   <= BUSY;
            mem_req_q <= 1'b1;
`endif
          end else if (iren && !halt) begin
            is_data_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= iaddr & WORD_MASK;
            mem_wdata_q <= '0;
            mem_strb_q  <= 4'b0000;
            state_q     <= BUSY;
            mem_req_q   <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (is_data_q) begin
              dhit_q <= 1'b1;
              if (!mem_wen_q) dload_q <= ext_data;
            end else begin
              ihit_q  <= 1'b1;
              iload_q <= mem_rdata;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ihit      = ihit_q;
  assign dhit      = dhit_q;
  assign iload     = iload_q;
  assign dload     = dload_q;
  assign mem_req   = mem_req_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_strb  = mem_strb_q;

endmodule
